// File: rtl/arith_pkg.sv
// Shared types and constants for the sequential arithmetic unit.
package arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    DIV    = 3'd3,
    FIN    = 3'd4
  } state_t;

  localparam logic [9:0] LED_ON = 10'h3FF;

endpackage

// File: rtl/arith_shift_core.sv
// Iterative datapath: one shift-add (multiply) or restoring-subtract (divide) step per cycle.
// The divide step exists only when SEQ_ARITH_DIV_EN is defined.
module arith_shift_core
  import arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic           div_mode,
  input  logic [W-1:0]   init,
  input  logic [W-1:0]   opnd,
  output logic [2*W-1:0] res,
  output logic           last
);

  localparam int CW = $clog2(W) + 1;

  logic [2*W-1:0] acc;
  logic [W-1:0]   sr;
  logic [CW-1:0]  cnt;
  logic [W:0]     mul_sum;

  // Multiply: add multiplicand into the upper half, then shift the whole product right.
  assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, (sr[0] ? opnd : {W{1'b0}})};
  assign last    = (cnt == CW'(W - 1));

`ifdef SEQ_ARITH_DIV_EN
  logic [W:0] rem_sh;
  logic       fits;
  logic [W:0] rem_diff;

  // Divide: remainder lives in acc upper half, quotient shifts into sr from the right.
  assign rem_sh   = {acc[2*W-1:W], sr[W-1]};
  assign fits     = (rem_sh >= {1'b0, opnd});
  assign rem_diff = rem_sh - {1'b0, opnd};
  assign res      = div_mode ? {acc[2*W-1:W], sr} : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      sr  <= init;
      cnt <= '0;
    end else if (step) begin
      cnt <= cnt + 1'b1;
      if (div_mode) begin
        acc <= {(fits ? rem_diff[W-1:0] : rem_sh[W-1:0]), acc[W-1:0]};
        sr  <= {sr[W-2:0], fits};
      end else begin
        acc <= {mul_sum, acc[W-1:1]};
        sr  <= sr >> 1;
      end
    end
  end
`else
  assign res = acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      sr  <= '0;
      cnt <= '0;
    end else if (load) begin
      acc <= '0;
      sr  <= init;
      cnt <= '0;
    end else if (step && !div_mode) begin
      cnt <= cnt + 1'b1;
      acc <= {mul_sum, acc[W-1:1]};
      sr  <= sr >> 1;
    end
  end
`endif

endmodule

// File: rtl/seq_arith_unit.sv
// Multi-cycle add/sub/multiply/divide unit with start/busy/done handshake and LED status.
// Restoring divider is built only when SEQ_ARITH_DIV_EN is defined; otherwise sel=3 reports unsupported.
module seq_arith_unit
  import arith_pkg::*;
#(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     sel,
  input  logic [W-1:0]   X,
  input  logic [W-1:0]   Y,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] out,
  output logic           flag,
  output logic [9:0]     LEDR
);

  state_t         state, state_nxt;
  op_t            op_q;
  logic [W-1:0]   a_q, b_q;
  logic           accept;
  logic [W:0]     sum;
  logic [W-1:0]   diff;
  logic [2*W-1:0] core_res, fin_out;
  logic           core_last, core_step, fin_flag;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          case (op_t'(sel))
            OP_MUL:  state_nxt = MUL;
`ifdef SEQ_ARITH_DIV_EN
            OP_DIV:  state_nxt = DIV;
`endif
            default: state_nxt = ADDSUB;
          endcase
        end
      end
      ADDSUB: state_nxt = FIN;
      MUL:    if (core_last) state_nxt = FIN;
`ifdef SEQ_ARITH_DIV_EN
      // A zero divisor skips the iterations entirely.
      DIV:    if (core_last || b_q == '0) state_nxt = FIN;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= X;
      b_q  <= Y;
      op_q <= op_t'(sel);
    end
  end

  assign core_step = (state == MUL) || ((state == DIV) && (b_q != '0));

  arith_shift_core #(.W(W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .step     (core_step),
    .div_mode (op_q == OP_DIV),
    .init     ((sel == 2'(OP_MUL)) ? Y : X),
    .opnd     ((op_q == OP_DIV) ? b_q : a_q),
    .res      (core_res),
    .last     (core_last)
  );

  assign sum  = {1'b0, a_q} + {1'b0, b_q};
  assign diff = a_q - b_q;

  always_comb begin
    fin_out  = '0;
    fin_flag = 1'b0;
    case (op_q)
      OP_ADD: begin
        fin_out  = {{(W-1){1'b0}}, sum};
        fin_flag = sum[W];
      end
      OP_SUB: begin
        fin_out  = {{W{1'b0}}, diff};
        fin_flag = (a_q < b_q);
      end
      OP_MUL: begin
        fin_out  = core_res;
        fin_flag = |core_res[2*W-1:W];
      end
      default: begin
`ifdef SEQ_ARITH_DIV_EN
        if (b_q == '0) begin
          fin_out  = {a_q, {W{1'b1}}};
          fin_flag = 1'b1;
        end else begin
          fin_out  = core_res;
          fin_flag = 1'b0;
        end
`else
        fin_flag = 1'b1;
`endif
      end
    endcase
  end

  // Result registers only change on the FIN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      out  <= '0;
      flag <= 1'b0;
      LEDR <= '0;
    end else if (state == FIN) begin
      out  <= fin_out;
      flag <= fin_flag;
      LEDR <= fin_flag ? LED_ON : 10'h000;
    end
  end

endmodule

// File: tb/tb_seq_arith_unit.sv
// Scoreboard bench for seq_arith_unit at W=4 and W=8.
module tb_seq_arith_unit;

  typedef struct {
    logic [15:0] out;
    logic        flag;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start4 = 1'b0, start8 = 1'b0;
  logic [1:0]  sel4 = '0, sel8 = '0;
  logic [3:0]  x4 = '0, y4 = '0;
  logic [7:0]  x8 = '0, y8 = '0;
  logic        busy4, done4, flag4, busy8, done8, flag8;
  logic [7:0]  out4;
  logic [15:0] out8;
  logic [9:0]  ledr4, ledr8;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  seq_arith_unit #(.W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .sel(sel4), .X(x4), .Y(y4),
    .busy(busy4), .done(done4), .out(out4), .flag(flag4), .LEDR(ledr4)
  );

  seq_arith_unit #(.W(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sel(sel8), .X(x8), .Y(y8),
    .busy(busy8), .done(done8), .out(out8), .flag(flag8), .LEDR(ledr8)
  );

  task automatic push_exp(input logic [15:0] o, input logic f, input int l);
    exp_t e;
    e.out = o; e.flag = f; e.lat = l;
    sb.push_back(e);
  endtask

  // Pulse start for one cycle; returns on the negedge after the accepting edge.
  task automatic issue4(input logic [1:0] s, input logic [3:0] x, input logic [3:0] y);
    @(negedge clk);
    sel4 = s; x4 = x; y4 = y; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    while (done4 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy4, done4, flag4} !== 3'b000) $display("FAIL reset_ctrl: busy/done/flag=%b want 000", {busy4, done4, flag4});
    else n_pass++;
    n_total++;
    if (out4 !== 8'h00 || ledr4 !== 10'h000) $display("FAIL reset_out: out=%h ledr=%h want 00/000", out4, ledr4);
    else n_pass++;
    n_total++;
    if (out8 !== 16'h0000 || busy8 !== 1'b0) $display("FAIL reset_w8: out=%h busy=%b want 0000/0", out8, busy8);
    else n_pass++;
    reset = 1'b0;
  endtask

  // Shared loop body for a list of W=4 ops whose expectations were pushed on issue.
  task automatic test_addsub;
    logic [1:0] ts [3] = '{2'd0, 2'd1, 2'd1};
    logic [3:0] tx [3] = '{4'd9, 4'd3, 4'd5};
    logic [3:0] ty [3] = '{4'd8, 4'd5, 4'd3};
    logic [7:0] to [3] = '{8'h11, 8'h0E, 8'h02};
    logic       tf [3] = '{1'b1, 1'b1, 1'b0};
    int n;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      push_exp({8'h00, to[i]}, tf[i], 1);
      issue4(ts[i], tx[i], ty[i]);
      wait_done4(n);
      e = sb.pop_front();
      n_total++;
      if (n !== e.lat) $display("FAIL addsub_lat[%0d]: got %0d want %0d", i, n, e.lat);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({8'h00, out4} !== e.out || flag4 !== e.flag) $display("FAIL addsub_res[%0d]: got %h/%b want %h/%b", i, out4, flag4, e.out, e.flag);
      else n_pass++;
      n_total++;
      if (ledr4 !== (e.flag ? 10'h3FF : 10'h000) || done4 !== 1'b0 || busy4 !== 1'b0) $display("FAIL addsub_after[%0d]: ledr=%h done=%b busy=%b want flag-led/0/0", i, ledr4, done4, busy4);
      else n_pass++;
    end
  endtask

  task automatic test_mul;
    logic [3:0] tx [2] = '{4'd13, 4'd3};
    logic [3:0] ty [2] = '{4'd11, 4'd5};
    logic [7:0] to [2] = '{8'h8F, 8'h0F};
    logic       tf [2] = '{1'b1, 1'b0};
    int n;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      push_exp({8'h00, to[i]}, tf[i], 4);
      issue4(2'd2, tx[i], ty[i]);
      wait_done4(n);
      e = sb.pop_front();
      n_total++;
      if (n !== e.lat) $display("FAIL mul_lat[%0d]: got %0d want %0d", i, n, e.lat);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({8'h00, out4} !== e.out || flag4 !== e.flag) $display("FAIL mul_res[%0d]: got %h/%b want %h/%b", i, out4, flag4, e.out, e.flag);
      else n_pass++;
    end
  endtask

  task automatic test_div;
    logic [3:0] tx [2] = '{4'd13, 4'd7};
    logic [3:0] ty [2] = '{4'd4, 4'd0};
`ifdef SEQ_ARITH_DIV_EN
    logic [7:0] to [2] = '{8'h13, 8'h7F};
    logic       tf [2] = '{1'b0, 1'b1};
    int         tl [2] = '{4, 1};
`else
    logic [7:0] to [2] = '{8'h00, 8'h00};
    logic       tf [2] = '{1'b1, 1'b1};
    int         tl [2] = '{1, 1};
`endif
    int n;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      push_exp({8'h00, to[i]}, tf[i], tl[i]);
      issue4(2'd3, tx[i], ty[i]);
      wait_done4(n);
      e = sb.pop_front();
      n_total++;
      if (n !== e.lat) $display("FAIL div_lat[%0d]: got %0d want %0d", i, n, e.lat);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({8'h00, out4} !== e.out || flag4 !== e.flag || ledr4 !== (e.flag ? 10'h3FF : 10'h000)) $display("FAIL div_res[%0d]: got %h/%b/%h want %h/%b", i, out4, flag4, ledr4, e.out, e.flag);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    int seen;
    exp_t e;
    issue4(2'd2, 4'd15, 4'd15);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_total++;
    if ({busy4, done4, flag4} !== 3'b000 || out4 !== 8'h00 || ledr4 !== 10'h000) $display("FAIL midreset_state: busy/done/flag=%b out=%h ledr=%h want all 0", {busy4, done4, flag4}, out4, ledr4);
    else n_pass++;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) seen++;
    end
    n_total++;
    if (seen !== 0) $display("FAIL midreset_quiet: saw %0d busy/done cycles want 0", seen);
    else n_pass++;
    push_exp(16'h0002, 1'b0, 1);
    issue4(2'd0, 4'd1, 4'd1);
    wait_done4(n);
    e = sb.pop_front();
    n_total++;
    if (n !== e.lat) $display("FAIL midreset_add_lat: got %0d want %0d", n, e.lat);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({8'h00, out4} !== e.out || flag4 !== e.flag) $display("FAIL midreset_add_res: got %h/%b want %h/%b", out4, flag4, e.out, e.flag);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int n;
    int extra;
    exp_t e;
    push_exp(16'h008F, 1'b1, 4);
    issue4(2'd2, 4'd13, 4'd11);
    @(negedge clk);
    sel4 = 2'd0; x4 = 4'd1; y4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; x4 = 4'd2; y4 = 4'd2;
    wait_done4(n);
    e = sb.pop_front();
    n_total++;
    if (n + 2 !== e.lat) $display("FAIL ignore_lat: got %0d want %0d", n + 2, e.lat);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({8'h00, out4} !== e.out || flag4 !== e.flag) $display("FAIL ignore_res: got %h/%b want %h/%b", out4, flag4, e.out, e.flag);
    else n_pass++;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy4 === 1'b1) extra++;
    end
    n_total++;
    if (extra !== 0) $display("FAIL ignore_queued: busy for %0d cycles want 0", extra);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int n;
    exp_t e;
    @(negedge clk);
    sel4 = 2'd0; x4 = 4'd2; y4 = 4'd3; start4 = 1'b1;
    push_exp(16'h0005, 1'b0, 2);
    wait_done4(n);
    x4 = 4'd6;
    push_exp(16'h0009, 1'b0, 2);
    e = sb.pop_front();
    n_total++;
    if (n !== e.lat) $display("FAIL b2b_lat0: got %0d want %0d", n, e.lat);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({8'h00, out4} !== e.out) $display("FAIL b2b_res0: got %h want %h", out4, e.out);
    else n_pass++;
    wait_done4(n);
    start4 = 1'b0;
    e = sb.pop_front();
    n_total++;
    if (n !== e.lat) $display("FAIL b2b_gap: got %0d want %0d", n, e.lat);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({8'h00, out4} !== e.out || flag4 !== e.flag) $display("FAIL b2b_res1: got %h/%b want %h/%b", out4, flag4, e.out, e.flag);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [1:0] s;
    logic [3:0] x, y;
    int n, r;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      s = 2'($urandom_range(0, 2));
      x = 4'($urandom_range(0, 15));
      y = 4'($urandom_range(0, 15));
      case (s)
        2'd0:    begin r = int'(x) + int'(y); push_exp(16'(r), r > 15, 1); end
        2'd1:    begin r = (int'(x) - int'(y)) & 15; push_exp(16'(r), x < y, 1); end
        default: begin r = int'(x) * int'(y); push_exp(16'(r), r > 15, 4); end
      endcase
      issue4(s, x, y);
      wait_done4(n);
      e = sb.pop_front();
      @(negedge clk);
      n_total++;
      if (n !== e.lat || {8'h00, out4} !== e.out || flag4 !== e.flag) $display("FAIL random[%0d] sel=%0d %0d,%0d: got lat %0d %h/%b want lat %0d %h/%b", i, s, x, y, n, out4, flag4, e.lat, e.out, e.flag);
      else n_pass++;
    end
  endtask

  task automatic test_w8;
    int n;
    exp_t e;
    push_exp(16'hFE01, 1'b1, 8);
    @(negedge clk);
    sel8 = 2'd2; x8 = 8'd255; y8 = 8'd255; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    n_total++;
    if (n !== e.lat) $display("FAIL w8_lat: got %0d want %0d", n, e.lat);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (out8 !== e.out || flag8 !== e.flag || ledr8 !== 10'h3FF) $display("FAIL w8_res: got %h/%b/%h want %h/%b/3ff", out8, flag8, ledr8, e.out, e.flag);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_addsub;
    test_mul;
    test_div;
    test_reset_mid;
    test_ignore_start;
    test_back_to_back;
    test_random;
    test_w8;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
